si5340_i2c_arbiter: RTL and testbench

//  Shares one I2C byte-command master (and its scl/sda pads) between NUM_REQ clients,
//  e.g. the si5340 config loader (client 0) and a status/LOL poller (client 1).

---
 rtl/si5340_i2c_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_si5340_i2c_arbiter.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/si5340_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// si5340_i2c_arbiter
//
// Purpose:
//   Shares one I2C byte-command master, and the scl/sda pads behind it,
//   between NUM_REQ clients. Typical clients are the si5340 config loader
//   (client 0) and a status/LOL poller (client 1).
//
//   A client owns the bus for a whole transaction: it holds req_i high for
//   as long as it needs the bus. While it owns the bus, its valid/ready
//   command channel is muxed through to the master. Responses from the
//   master are registered and routed back to the owner.
//
//   After each transaction the arbiter waits for the master to go idle and
//   then enforces a bus-free gap before it grants the bus again. A watchdog
//   revokes a grant that is held too long. A revoked client is blocked until
//   it drops its request.
//
// Configuration macro:
//   SI5340_ARB_FIXED_PRIO_EN
//     Defined   : fixed priority. The lowest-index requester always wins, so
//                 the config loader (client 0) beats every other client.
//     Undefined : round-robin. The search starts just after the previous
//                 owner. This is the default build.
//   The watchdog, the gap and the blocking logic are the same in both builds.
//
// Parameters:
//   NUM_REQ      number of clients (2..8)
//   CMD_W        command word width (op + byte)
//   RSP_W        response word width
//   GAP_CYC      idle cycles required between release and next grant (>=1)
//   TIMEOUT_CYC  maximum cycles a grant may be held (>=2)
//
// Ports:
//   clk_i          clock
//   arstn_i        asynchronous reset, active low
//   req_i          per-client transaction request (level)
//   gnt_o          one-hot grant, registered
//   cmd_valid_i    per-client command valid
//   cmd_data_i     per-client command, client k at [k*CMD_W +: CMD_W]
//   cmd_ready_o    per-client command ready (only the owner's can be high)
//   rsp_valid_o    per-client response valid, 1-cycle pulse
//   rsp_data_o     response data, shared by all clients
//   m_valid_o      command valid to master
//   m_data_o       command to master
//   m_ready_i      master accepts command
//   m_busy_i       master mid-transfer (bus not free)
//   m_rsp_valid_i  master response valid
//   m_rsp_data_i   master response data
//   timeout_o      1-cycle pulse when the watchdog revokes a grant
// ---------------------------------------------------------------------------
module si5340_i2c_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int CMD_W       = 16,
  parameter int RSP_W       = 8,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic [NUM_REQ-1:0]       req_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  input  logic [NUM_REQ-1:0]       cmd_valid_i,
  input  logic [NUM_REQ*CMD_W-1:0] cmd_data_i,
  output logic [NUM_REQ-1:0]       cmd_ready_o,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [RSP_W-1:0]         rsp_data_o,
  output logic                     m_valid_o,
  output logic [CMD_W-1:0]         m_data_o,
  input  logic                     m_ready_i,
  input  logic                     m_busy_i,
  input  logic                     m_rsp_valid_i,
  input  logic [RSP_W-1:0]         m_rsp_data_i,
  output logic                     timeout_o
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  // Terminal counts. Each counter stops at its terminal value and never wraps.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state;
  logic [OWN_W-1:0]   owner;
  logic [NUM_REQ-1:0] blocked;
  logic [TMR_W-1:0]   timer;
  logic [GAP_W-1:0]   gap_cnt;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [OWN_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] owner_oh;
  logic               owner_req;
  logic               owner_cmd_valid;
  logic [CMD_W-1:0]   owner_data;

  // Decode the owner into a one-hot mask. The mask selects the owner's
  // request, valid, ready and response bits without indexing out of range.
  always_comb begin
    owner_oh        = NUM_REQ'(1) << owner;
    owner_req       = |(req_i & owner_oh);
    owner_cmd_valid = |(cmd_valid_i & owner_oh);
    eligible        = req_i & ~blocked;
  end

  // Select the owner's command word from the packed per-client bus.
  always_comb begin
    owner_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner == OWN_W'(k)) begin
        owner_data = cmd_data_i[k*CMD_W +: CMD_W];
      end
    end
  end

`ifdef SI5340_ARB_FIXED_PRIO_EN
  // Fixed priority. The loop scans downward so that the last match, which
  // is the lowest eligible index, wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        pick_found = 1'b1;
        pick_idx   = OWN_W'(k);
      end
    end
  end
`else
  logic [OWN_W-1:0] rr_ptr;

  // Index that lies step positions after base, wrapping modulo NUM_REQ.
  // NUM_REQ need not be a power of two, so the wrap is explicit.
  function automatic logic [OWN_W-1:0] rr_index(input logic [OWN_W-1:0] base,
                                                input int               step);
    int idx;
    idx = int'(base) + step;
    if (idx >= NUM_REQ) begin
      idx = idx - NUM_REQ;
    end
    return OWN_W'(idx);
  endfunction

  // Round-robin. The loop scans from the farthest distance down to the
  // nearest, so the closest eligible client after rr_ptr wins. The last
  // owner itself is at distance NUM_REQ, so it has the lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (eligible[rr_index(rr_ptr, i)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_index(rr_ptr, i);
      end
    end
  end
`endif

  // Command path. The path is open only in GRANT. Outside GRANT the master
  // sees no valid, and no client sees ready.
  always_comb begin
    m_valid_o   = 1'b0;
    m_data_o    = '0;
    cmd_ready_o = '0;
    if (state == GRANT) begin
      m_valid_o   = owner_cmd_valid;
      m_data_o    = owner_data;
      cmd_ready_o = m_ready_i ? owner_oh : '0;
    end
  end

  // Main arbiter FSM with registered grant, response and timeout outputs.
  // The owner register is kept through DRAIN, so a response that arrives
  // after release still reaches the client that started the transfer.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state       <= IDLE;
      owner       <= '0;
      blocked     <= '0;
      timer       <= '0;
      gap_cnt     <= '0;
      gnt_o       <= '0;
      timeout_o   <= 1'b0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
`ifndef SI5340_ARB_FIXED_PRIO_EN
      rr_ptr      <= OWN_W'(NUM_REQ - 1);
`endif
    end else begin
      timeout_o   <= 1'b0;
      rsp_valid_o <= '0;
      // A blocked client is released as soon as its request is seen low.
      blocked     <= blocked & req_i;

      if (((state == GRANT) || (state == DRAIN)) && m_rsp_valid_i) begin
        rsp_valid_o <= owner_oh;
        rsp_data_o  <= m_rsp_data_i;
      end

      unique case (state)
        IDLE: begin
          if (pick_found) begin
            owner  <= pick_idx;
            gnt_o  <= NUM_REQ'(1) << pick_idx;
            timer  <= '0;
            state  <= GRANT;
`ifndef SI5340_ARB_FIXED_PRIO_EN
            rr_ptr <= pick_idx;
`endif
          end
        end

        GRANT: begin
          // If release and the watchdog expiry land on the same cycle, the
          // release wins. No pulse is raised and no block is applied.
          if (!owner_req) begin
            gnt_o <= '0;
            state <= DRAIN;
          end else if (timer == TMR_LAST) begin
            gnt_o     <= '0;
            state     <= DRAIN;
            timeout_o <= 1'b1;
            blocked   <= (blocked & req_i) | owner_oh;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DRAIN: begin
          if (!m_busy_i) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end

        GAP: begin
          // Every cycle of the gap must see a free bus. Any busy cycle
          // restarts the count.
          if (m_busy_i) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_si5340_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// tb_si5340_i2c_arbiter
//
// Purpose:
//   Self-checking bench for si5340_i2c_arbiter.
//
//   The DUT is built with a short watchdog and a short gap so that every
//   scenario stays small. Each scenario task drives its own stimulus and
//   compares results inline. Expected commands, responses and grant order
//   are pushed to queues when the stimulus is driven. They are popped and
//   compared when the DUT produces the matching output.
//
//   The bench honours SI5340_ARB_FIXED_PRIO_EN for the expected grant order.
// ---------------------------------------------------------------------------
module tb_si5340_i2c_arbiter;

  localparam int GAP = 5;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        arstn_i;
  logic [1:0]  req_i;
  logic [1:0]  gnt_o;
  logic [1:0]  cmd_valid_i;
  logic [31:0] cmd_data_i;
  logic [1:0]  cmd_ready_o;
  logic [1:0]  rsp_valid_o;
  logic [7:0]  rsp_data_o;
  logic        m_valid_o;
  logic [15:0] m_data_o;
  logic        m_ready_i;
  logic        m_busy_i;
  logic        m_rsp_valid_i;
  logic [7:0]  m_rsp_data_i;
  logic        timeout_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] vld;
    logic [7:0] data;
    int         due;
  } rsp_exp_t;

  logic [15:0] exp_cmd_q[$];
  rsp_exp_t    exp_rsp_q[$];

  si5340_i2c_arbiter #(
    .NUM_REQ(2), .CMD_W(16), .RSP_W(8), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk), .arstn_i(arstn_i), .req_i(req_i), .gnt_o(gnt_o),
    .cmd_valid_i(cmd_valid_i), .cmd_data_i(cmd_data_i), .cmd_ready_o(cmd_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .m_valid_o(m_valid_o),
    .m_data_o(m_data_o), .m_ready_i(m_ready_i), .m_busy_i(m_busy_i),
    .m_rsp_valid_i(m_rsp_valid_i), .m_rsp_data_i(m_rsp_data_i), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Hard stop in case a scenario never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_i         = 2'b00;
    cmd_valid_i   = 2'b00;
    cmd_data_i    = '0;
    m_ready_i     = 1'b0;
    m_busy_i      = 1'b0;
    m_rsp_valid_i = 1'b0;
    m_rsp_data_i  = 8'h00;
  endtask

  task automatic do_reset(input logic [1:0] req_during);
    arstn_i = 1'b0;
    idle_inputs();
    req_i = req_during;
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    next_cycle();
    next_cycle();
    arstn_i = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    arstn_i = 1'b0;
    idle_inputs();
    req_i         = 2'b11;
    cmd_valid_i   = 2'b11;
    m_ready_i     = 1'b1;
    m_rsp_valid_i = 1'b1;
    m_rsp_data_i  = 8'h77;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_gnt: got %b expected 00", gnt_o);
    end
    checks++;
    if ({cmd_ready_o, rsp_valid_o, m_valid_o, timeout_o} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 000000",
               {cmd_ready_o, rsp_valid_o, m_valid_o, timeout_o});
    end
    m_rsp_valid_i = 1'b0;
    next_cycle();
    arstn_i = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_release_gnt: got %b expected 00", gnt_o);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++;
      $display("[TB] FAIL first_grant: got %b expected 01", gnt_o);
    end
    checks++;
    if (m_valid_o !== 1'b1 || cmd_ready_o !== 2'b01) begin
      errors++;
      $display("[TB] FAIL first_grant_path: got valid=%b ready=%b expected 1 01",
               m_valid_o, cmd_ready_o);
    end
    // Asynchronous reset in the middle of a transaction.
    arstn_i = 1'b0;
    #1;
    checks++;
    if (gnt_o !== 2'b00 || m_valid_o !== 1'b0 || cmd_ready_o !== 2'b00) begin
      errors++;
      $display("[TB] FAIL async_reset: got gnt=%b valid=%b ready=%b expected 00 0 00",
               gnt_o, m_valid_o, cmd_ready_o);
    end
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_g_q[$];
    logic [1:0]  exp_g;
    logic [15:0] exp_w;
    int          sent[2];
    int          word[2];
    bit          drop[2];
    logic [1:0]  prev_g;
    int          idle;
    int          grants;
    $display("[TB] test_alternate");
    do_reset(2'b00);
`ifdef SI5340_ARB_FIXED_PRIO_EN
    exp_g_q = '{2'b01, 2'b01, 2'b01};
`else
    exp_g_q = '{2'b01, 2'b10, 2'b01};
`endif
    for (int k = 0; k < 2; k++) begin
      sent[k] = 0;
      word[k] = 0;
      drop[k] = 1'b0;
    end
    prev_g    = 2'b00;
    idle      = 0;
    grants    = 0;
    m_ready_i = 1'b1;
    for (int n = 0; n < 400 && grants < 3; n++) begin
      for (int k = 0; k < 2; k++) begin
        req_i[k]              = !drop[k];
        cmd_valid_i[k]        = !drop[k] && (sent[k] < 3);
        cmd_data_i[k*16 +: 16] = 16'((k + 1) * 'h1000 + word[k]);
      end
      @(negedge clk);
      checks++;
      if ((cmd_ready_o & ~gnt_o) !== 2'b00) begin
        errors++;
        $display("[TB] FAIL alt_nonowner_ready: got ready=%b gnt=%b expected no ready outside grant",
                 cmd_ready_o, gnt_o);
      end
      if (gnt_o !== 2'b00 && prev_g === 2'b00) begin
        checks++;
        if (exp_g_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL alt_grant_extra: got %b expected no further grant", gnt_o);
        end else begin
          exp_g = exp_g_q.pop_front();
          if (gnt_o !== exp_g) begin
            errors++;
            $display("[TB] FAIL alt_grant_order: got %b expected %b", gnt_o, exp_g);
          end
        end
        if (grants > 0) begin
          checks++;
          if (idle != GAP + 2) begin
            errors++;
            $display("[TB] FAIL alt_gap: got %0d idle cycles expected %0d", idle, GAP + 2);
          end
        end
        idle = 0;
        grants++;
      end
      if (gnt_o === 2'b00) idle++;
      prev_g = gnt_o;
      for (int k = 0; k < 2; k++) begin
        if (drop[k]) begin
          drop[k] = 1'b0;
          sent[k] = 0;
        end else if (cmd_valid_i[k] && cmd_ready_o[k]) begin
          checks++;
          exp_w = 16'((k + 1) * 'h1000 + word[k]);
          if (m_valid_o !== 1'b1 || m_data_o !== exp_w) begin
            errors++;
            $display("[TB] FAIL alt_cmd: got valid=%b data=%h expected 1 %h",
                     m_valid_o, m_data_o, exp_w);
          end
          word[k]++;
          sent[k]++;
          if (sent[k] == 3) drop[k] = 1'b1;
        end
      end
      next_cycle();
    end
    checks++;
    if (grants != 3 || exp_g_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL alt_budget: got %0d grants expected 3", grants);
    end
  endtask

  task automatic test_owner_mux();
    logic [15:0] w[2];
    logic [15:0] exp_w;
    logic        exp_ready;
    int          idx;
    $display("[TB] test_owner_mux");
    do_reset(2'b00);
    w[0] = 16'h1234;
    w[1] = 16'h5678;
    exp_cmd_q.push_back(w[0]);
    exp_cmd_q.push_back(w[1]);
    idx = 0;
    for (int n = 0; n < 40 && idx < 2; n++) begin
      req_i       = 2'b10;
      cmd_valid_i = 2'b11;
      cmd_data_i  = {w[idx], 16'hDEAD};
      m_ready_i   = (n % 2) == 1;
      @(negedge clk);
      checks++;
      if (cmd_ready_o[0] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mux_client0_ready: got %b expected 0", cmd_ready_o[0]);
      end
      exp_ready = (n >= 1) && m_ready_i;
      checks++;
      if (cmd_ready_o[1] !== exp_ready) begin
        errors++;
        $display("[TB] FAIL mux_client1_ready: got %b expected %b", cmd_ready_o[1], exp_ready);
      end
      if (m_valid_o && m_ready_i) begin
        checks++;
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL mux_cmd_extra: got %h expected none", m_data_o);
        end else begin
          exp_w = exp_cmd_q.pop_front();
          if (m_data_o !== exp_w) begin
            errors++;
            $display("[TB] FAIL mux_cmd_data: got %h expected %h", m_data_o, exp_w);
          end
        end
      end
      if (cmd_valid_i[1] && cmd_ready_o[1]) idx++;
      next_cycle();
    end
    checks++;
    if (exp_cmd_q.size() != 0 || idx != 2) begin
      errors++;
      $display("[TB] FAIL mux_budget: got %0d sent expected 2", idx);
    end
  endtask

  task automatic test_timeout();
    logic       prev_g;
    int         rises;
    int         rise_n[2];
    int         fall_n;
    int         tmo_cnt;
    int         tmo_n;
    $display("[TB] test_timeout");
    do_reset(2'b00);
    prev_g  = 1'b0;
    rises   = 0;
    rise_n  = '{-1, -1};
    fall_n  = -1;
    tmo_cnt = 0;
    tmo_n   = -1;
    for (int n = 0; n < 50; n++) begin
      req_i = {1'b0, ((n < 40) || (n >= 43))};
      @(negedge clk);
      if (gnt_o[0] && !prev_g) begin
        if (rises < 2) rise_n[rises] = n;
        rises++;
      end
      if (!gnt_o[0] && prev_g && fall_n < 0) fall_n = n;
      if (timeout_o) begin
        tmo_cnt++;
        tmo_n = n;
      end
      prev_g = gnt_o[0];
      next_cycle();
    end
    checks++;
    if (rise_n[0] != 1 || fall_n != 1 + TMO) begin
      errors++;
      $display("[TB] FAIL tmo_grant_window: got rise=%0d fall=%0d expected 1 %0d",
               rise_n[0], fall_n, 1 + TMO);
    end
    checks++;
    if (tmo_cnt != 1 || tmo_n != 1 + TMO) begin
      errors++;
      $display("[TB] FAIL tmo_pulse: got count=%0d at=%0d expected 1 at %0d",
               tmo_cnt, tmo_n, 1 + TMO);
    end
    checks++;
    if (rises != 2 || rise_n[1] != 44) begin
      errors++;
      $display("[TB] FAIL tmo_block: got rises=%0d second=%0d expected 2 at 44",
               rises, rise_n[1]);
    end
  endtask

  task automatic test_timeout_release_race();
    logic prev_g;
    int   rises;
    int   rise_n[2];
    int   fall_n;
    int   tmo_cnt;
    $display("[TB] test_timeout_release_race");
    do_reset(2'b00);
    prev_g  = 1'b0;
    rises   = 0;
    rise_n  = '{-1, -1};
    fall_n  = -1;
    tmo_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      req_i = {1'b0, (n != TMO)};
      @(negedge clk);
      if (gnt_o[0] && !prev_g) begin
        if (rises < 2) rise_n[rises] = n;
        rises++;
      end
      if (!gnt_o[0] && prev_g && fall_n < 0) fall_n = n;
      if (timeout_o) tmo_cnt++;
      prev_g = gnt_o[0];
      next_cycle();
    end
    checks++;
    if (tmo_cnt != 0) begin
      errors++;
      $display("[TB] FAIL race_no_timeout: got %0d pulses expected 0", tmo_cnt);
    end
    checks++;
    if (fall_n != TMO + 1) begin
      errors++;
      $display("[TB] FAIL race_release: got fall=%0d expected %0d", fall_n, TMO + 1);
    end
    checks++;
    if (rises != 2 || rise_n[1] != TMO + 3 + GAP) begin
      errors++;
      $display("[TB] FAIL race_no_block: got rises=%0d second=%0d expected 2 at %0d",
               rises, rise_n[1], TMO + 3 + GAP);
    end
  endtask

  task automatic test_release_busy();
    rsp_exp_t    e;
    logic [15:0] exp_w;
    logic        prev_g1;
    int          rise1_n;
    $display("[TB] test_release_busy");
    do_reset(2'b00);
    prev_g1 = 1'b0;
    rise1_n = -1;
    for (int n = 0; n < 30; n++) begin
      req_i         = {(n >= 2), (n <= 1)};
      cmd_valid_i   = {1'b0, ((n == 1) || (n == 3) || (n == 4))};
      cmd_data_i    = {16'h0000, 16'hC0DE};
      m_ready_i     = 1'b1;
      m_busy_i      = (n >= 2) && (n <= 11);
      m_rsp_valid_i = (n == 7) || (n == 14);
      m_rsp_data_i  = (n == 7) ? 8'hA5 : 8'h3C;
      if (n == 1) exp_cmd_q.push_back(16'hC0DE);
      if (n == 7) begin
        e.vld  = 2'b01;
        e.data = 8'hA5;
        e.due  = n + 1;
        exp_rsp_q.push_back(e);
      end
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (gnt_o !== 2'b01) begin
          errors++;
          $display("[TB] FAIL busy_grant: got %b expected 01", gnt_o);
        end
      end
      if (n == 3) begin
        checks++;
        if (gnt_o !== 2'b00 || m_valid_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL busy_drain_closed: got gnt=%b valid=%b expected 00 0",
                   gnt_o, m_valid_o);
        end
      end
      if (m_valid_o && m_ready_i) begin
        checks++;
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL busy_cmd_extra: got %h expected none", m_data_o);
        end else begin
          exp_w = exp_cmd_q.pop_front();
          if (m_data_o !== exp_w) begin
            errors++;
            $display("[TB] FAIL busy_cmd_data: got %h expected %h", m_data_o, exp_w);
          end
        end
      end
      if (rsp_valid_o !== 2'b00) begin
        checks++;
        if (exp_rsp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rsp_unexpected: got valid=%b data=%h at %0d expected none",
                   rsp_valid_o, rsp_data_o, n);
        end else begin
          e = exp_rsp_q.pop_front();
          if (rsp_valid_o !== e.vld || rsp_data_o !== e.data || n != e.due) begin
            errors++;
            $display("[TB] FAIL rsp_route: got valid=%b data=%h at %0d expected %b %h at %0d",
                     rsp_valid_o, rsp_data_o, n, e.vld, e.data, e.due);
          end
        end
      end
      if (exp_rsp_q.size() != 0 && exp_rsp_q[0].due < n) begin
        checks++;
        errors++;
        e = exp_rsp_q.pop_front();
        $display("[TB] FAIL rsp_missing: got nothing expected %b %h at %0d",
                 e.vld, e.data, e.due);
      end
      if (gnt_o[1] && !prev_g1 && rise1_n < 0) rise1_n = n;
      prev_g1 = gnt_o[1];
      next_cycle();
    end
    checks++;
    if (exp_rsp_q.size() != 0 || exp_cmd_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL busy_queue_left: got rsp=%0d cmd=%0d expected 0 0",
               exp_rsp_q.size(), exp_cmd_q.size());
    end
    // Busy is low from cycle 12. DRAIN exits on that cycle and the gap runs
    // for GAP cycles. One IDLE cycle follows, then the grant appears.
    checks++;
    if (rise1_n != 12 + GAP + 2) begin
      errors++;
      $display("[TB] FAIL busy_next_grant: got %0d expected %0d", rise1_n, 12 + GAP + 2);
    end
  endtask

  initial begin
    idle_inputs();
    arstn_i = 1'b0;
    test_reset();
    test_alternate();
    test_owner_mux();
    test_timeout();
    test_timeout_release_race();
    test_release_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
